// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wport_arbiter
// Description : Owns the single write port of the integer register file.
//               Arbitrates the port between the in-order WB stage and the
//               out-of-order mul/div result stream. The mul/div results are
//               buffered in a small FIFO. A 32-entry busy scoreboard tracks
//               registers that have a multicycle write outstanding, and ID is
//               stalled on RAW/WAW hazards against them.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH      mul/div result buffer entries (power of two, >= 2)
//   STARVE_MAX      consecutive cycles a non-empty FIFO may lose to WB
// Ports
//   clk_100MHz      in   clock
//   arst_n          in   synchronous active-low reset
//   wb_w_e_i        in   WB write request
//   wb_w_addr_i     in   WB destination register
//   wb_w_data_i     in   WB write data
//   wb_hold_o       out  WB must re-present the same write next cycle
//   md_valid_i      in   mul/div result valid
//   md_addr_i       in   mul/div destination register
//   md_data_i       in   mul/div result
//   md_ready_o      out  FIFO can accept a result
//   md_issue_i      in   mul/div instruction issued this cycle
//   md_issue_addr_i in   destination of the issued instruction
//   id_rs1_addr_i   in   ID source 1
//   id_rs2_addr_i   in   ID source 2
//   id_rd_addr_i    in   ID destination
//   id_rd_we_i      in   ID instruction writes rd
//   id_stall_o      out  ID must stall
//   w_e_o           out  register file write enable
//   w_addr_o        out  register file write address
//   w_data_o        out  register file write data
// Configuration macro
//   REG_WR_BYPASS_EN  when defined, a mul/div result arriving while the FIFO
//                     is empty and WB is not granted is written straight to
//                     the register file in the same cycle.
// ============================================================================
module regfile_wport_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_100MHz,
    input  logic        arst_n,
    input  logic        wb_w_e_i,
    input  logic [4:0]  wb_w_addr_i,
    input  logic [31:0] wb_w_data_i,
    output logic        wb_hold_o,
    input  logic        md_valid_i,
    input  logic [4:0]  md_addr_i,
    input  logic [31:0] md_data_i,
    output logic        md_ready_o,
    input  logic        md_issue_i,
    input  logic [4:0]  md_issue_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_rd_we_i,
    output logic        id_stall_o,
    output logic        w_e_o,
    output logic [4:0]  w_addr_o,
    output logic [31:0] w_data_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(FIFO_DEPTH);
    localparam logic [ST_W-1:0]  C_STARVE_MAX = ST_W'(STARVE_MAX);

    // FIFO storage (data path only, no reset needed)
    logic [4:0]       fifo_addr_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic [31:0]      busy_q,   busy_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             wb_valid;
    logic             wb_grant;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             md_fire;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == C_DEPTH);
        head_addr  = fifo_addr_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
        // A WB write to x0 is discarded and never competes with the FIFO.
        wb_valid   = wb_w_e_i && (wb_w_addr_i != 5'd0);

        wb_grant   = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;
        md_fire    = 1'b0;
        wb_hold_o  = 1'b0;
        md_ready_o = 1'b0;
        id_stall_o = 1'b0;
        w_e_o      = 1'b0;
        w_addr_o   = 5'd0;
        w_data_o   = 32'd0;

        if (arst_n) begin
            md_ready_o = !fifo_full;
            // Results targeting x0 are accepted but dropped.
            md_fire    = md_valid_i && !fifo_full && (md_addr_i != 5'd0);

            if (!fifo_empty && (starve_q == C_STARVE_MAX)) begin
                pop       = 1'b1;
                wb_hold_o = wb_valid;
            end else if (wb_valid) begin
                wb_grant  = 1'b1;
            end else if (!fifo_empty) begin
                pop       = 1'b1;
            end
`ifdef REG_WR_BYPASS_EN
            else if (md_fire) begin
                bypass    = 1'b1;
            end
`endif

            if (pop) begin
                w_e_o    = 1'b1;
                w_addr_o = head_addr;
                w_data_o = head_data;
            end else if (wb_grant) begin
                w_e_o    = 1'b1;
                w_addr_o = wb_w_addr_i;
                w_data_o = wb_w_data_i;
            end else if (bypass) begin
                w_e_o    = 1'b1;
                w_addr_o = md_addr_i;
                w_data_o = md_data_i;
            end

            id_stall_o = busy_q[id_rs1_addr_i] | busy_q[id_rs2_addr_i]
                       | (id_rd_we_i & busy_q[id_rd_addr_i]);
        end

        push = md_fire && !bypass;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Starvation counts only cycles where WB wins against a waiting entry.
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (wb_grant && (starve_q != C_STARVE_MAX)) begin
            starve_d = starve_q + ST_W'(1);
        end

        // Clear first so that a same-cycle issue to the same register wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (bypass) begin
            busy_d[md_addr_i] = 1'b0;
        end
        if (arst_n && md_issue_i && (md_issue_addr_i != 5'd0)) begin
            busy_d[md_issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= md_addr_i;
            fifo_data_q[wr_ptr_q] <= md_data_i;
        end
    end

`ifndef SYNTHESIS
    // WB must never target a register that still awaits a mul/div result.
    always_ff @(posedge clk_100MHz) begin
        if (arst_n && wb_grant) begin
            assert (!busy_q[wb_w_addr_i])
            else $error("regfile_wport_arbiter: WB write to busy register x%0d", wb_w_addr_i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wport_arbiter
// Description : Directed self-checking bench for regfile_wport_arbiter
//               (default build, bypass disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wport_arbiter;

    logic        clk_100MHz = 1'b0;
    logic        arst_n;
    logic        wb_w_e_i;
    logic [4:0]  wb_w_addr_i;
    logic [31:0] wb_w_data_i;
    logic        wb_hold_o;
    logic        md_valid_i;
    logic [4:0]  md_addr_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic        md_issue_i;
    logic [4:0]  md_issue_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    logic        id_stall_o;
    logic        w_e_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;

    int checks   = 0;
    int failures = 0;

    regfile_wport_arbiter #(
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clk_100MHz      (clk_100MHz),
        .arst_n          (arst_n),
        .wb_w_e_i        (wb_w_e_i),
        .wb_w_addr_i     (wb_w_addr_i),
        .wb_w_data_i     (wb_w_data_i),
        .wb_hold_o       (wb_hold_o),
        .md_valid_i      (md_valid_i),
        .md_addr_i       (md_addr_i),
        .md_data_i       (md_data_i),
        .md_ready_o      (md_ready_o),
        .md_issue_i      (md_issue_i),
        .md_issue_addr_i (md_issue_addr_i),
        .id_rs1_addr_i   (id_rs1_addr_i),
        .id_rs2_addr_i   (id_rs2_addr_i),
        .id_rd_addr_i    (id_rd_addr_i),
        .id_rd_we_i      (id_rd_we_i),
        .id_stall_o      (id_stall_o),
        .w_e_o           (w_e_o),
        .w_addr_o        (w_addr_o),
        .w_data_o        (w_data_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_w_e_i        = 1'b0;
        wb_w_addr_i     = 5'd0;
        wb_w_data_i     = 32'd0;
        md_valid_i      = 1'b0;
        md_addr_i       = 5'd0;
        md_data_i       = 32'd0;
        md_issue_i      = 1'b0;
        md_issue_addr_i = 5'd0;
        id_rs1_addr_i   = 5'd0;
        id_rs2_addr_i   = 5'd0;
        id_rd_addr_i    = 5'd0;
        id_rd_we_i      = 1'b0;
    endtask

    // Advance to just after the next rising edge, where new inputs are applied.
    task automatic next();
        @(posedge clk_100MHz);
        #1;
        idle();
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_w_e_i    = 1'b1;
        wb_w_addr_i = a;
        wb_w_data_i = d;
    endtask

    task automatic md(input logic [4:0] a, input logic [31:0] d);
        md_valid_i = 1'b1;
        md_addr_i  = a;
        md_data_i  = d;
    endtask

    task automatic issue(input logic [4:0] a);
        md_issue_i      = 1'b1;
        md_issue_addr_i = a;
    endtask

    initial begin
        // ---------------- reset with active requests ----------------
        idle();
        arst_n = 1'b0;
        md(5'd3, 32'h1234_5678);
        wb(5'd4, 32'hAAAA_5555);
        issue(5'd6);
        id_rs1_addr_i = 5'd6;
        #2;
        chk("rst_w_e",     w_e_o,      0);
        chk("rst_w_addr",  w_addr_o,   0);
        chk("rst_w_data",  w_data_o,   0);
        chk("rst_ready",   md_ready_o, 0);
        chk("rst_hold",    wb_hold_o,  0);
        chk("rst_stall",   id_stall_o, 0);
        @(posedge clk_100MHz);
        @(posedge clk_100MHz);
        #1;
        chk("rst_w_e_2",   w_e_o,      0);

        next();
        arst_n = 1'b1;
        id_rs1_addr_i = 5'd6;
        id_rs2_addr_i = 5'd3;
        #1;
        chk("post_rst_ready", md_ready_o, 1);
        chk("post_rst_w_e",   w_e_o,      0);
        chk("post_rst_stall", id_stall_o, 0);

        // ---------------- issue x5, result one cycle later ----------------
        next(); issue(5'd5); #1;
        chk("x5_issue_w_e", w_e_o, 0);
        next(); md(5'd5, 32'hDEAD_BEEF); id_rs1_addr_i = 5'd5; #1;
        chk("x5_push_w_e",  w_e_o,      0);
        chk("x5_stall_a",   id_stall_o, 1);
        next(); id_rs1_addr_i = 5'd5; #1;
        chk("x5_w_e",       w_e_o,      1);
        chk("x5_w_addr",    w_addr_o,   5);
        chk("x5_w_data",    w_data_o,   32'hDEAD_BEEF);
        chk("x5_stall_b",   id_stall_o, 1);
        next(); id_rs1_addr_i = 5'd5; #1;
        chk("x5_after_w_e", w_e_o,      0);
        chk("x5_stall_clr", id_stall_o, 0);

        // ---------------- starvation: WB every cycle ----------------
        next(); issue(5'd7); #1;
        next(); md(5'd7, 32'h77); wb(5'd1, 32'h101); id_rs2_addr_i = 5'd7; #1;
        chk("st_wb1_addr", w_addr_o,   1);
        chk("st_stall_1",  id_stall_o, 1);
        for (int k = 2; k <= 5; k++) begin
            next(); wb(5'(k), 32'h100 + 32'(k)); id_rs2_addr_i = 5'd7; #1;
            chk("st_wb_addr", w_addr_o,   32'(k));
            chk("st_wb_data", w_data_o,   32'h100 + 32'(k));
            chk("st_hold0",   wb_hold_o,  0);
            chk("st_stall",   id_stall_o, 1);
        end
        next(); wb(5'd6, 32'h106); #1;
        chk("st_fifo_w_e",  w_e_o,     1);
        chk("st_fifo_addr", w_addr_o,  7);
        chk("st_fifo_data", w_data_o,  32'h77);
        chk("st_hold1",     wb_hold_o, 1);
        next(); wb(5'd6, 32'h106); id_rs2_addr_i = 5'd7; #1;
        chk("st_replay_addr", w_addr_o,   6);
        chk("st_replay_data", w_data_o,   32'h106);
        chk("st_replay_hold", wb_hold_o,  0);
        chk("st_stall_clr",   id_stall_o, 0);
        next(); #1;
        chk("st_idle_w_e", w_e_o, 0);

        // ---------------- pop x7 and re-issue x7 same cycle ----------------
        next(); issue(5'd7); #1;
        next(); md(5'd7, 32'h70); #1;
        chk("ss_push_w_e", w_e_o, 0);
        next(); issue(5'd7); #1;
        chk("ss_pop_addr", w_addr_o, 7);
        chk("ss_pop_data", w_data_o, 32'h70);
        next(); id_rs1_addr_i = 5'd7; md(5'd7, 32'h71); #1;
        chk("ss_busy_kept", id_stall_o, 1);
        next(); id_rs1_addr_i = 5'd7; #1;
        chk("ss_pop2_data", w_data_o,   32'h71);
        chk("ss_stall_b",   id_stall_o, 1);
        next(); id_rs1_addr_i = 5'd7; #1;
        chk("ss_stall_clr", id_stall_o, 0);

        // ---------------- fill FIFO while WB busy ----------------
        next(); wb(5'd8, 32'h108); md(5'd9, 32'h9); #1;
        chk("fill_ready_a", md_ready_o, 1);
        chk("fill_wb_a",    w_data_o,   32'h108);
        next(); wb(5'd8, 32'h208); md(5'd10, 32'hA); #1;
        chk("fill_ready_b", md_ready_o, 1);
        chk("fill_wb_b",    w_data_o,   32'h208);
        next(); wb(5'd8, 32'h308); md(5'd11, 32'hB); #1;
        chk("fill_full",    md_ready_o, 0);
        chk("fill_wb_c",    w_data_o,   32'h308);
        next(); #1;
        chk("fill_pop_ready", md_ready_o, 0);
        chk("fill_pop_addr",  w_addr_o,   9);
        chk("fill_pop_data",  w_data_o,   32'h9);
        next(); #1;
        chk("fill_ready_ret", md_ready_o, 1);
        chk("fill_pop2_addr", w_addr_o,   10);
        chk("fill_pop2_data", w_data_o,   32'hA);
        next(); #1;
        chk("fill_empty_w_e", w_e_o, 0);

        // ---------------- x0 traffic ----------------
        next(); md(5'd0, 32'h55); wb(5'd0, 32'h66);
        id_rd_we_i = 1'b1; #1;
        chk("x0_w_e",   w_e_o,      0);
        chk("x0_hold",  wb_hold_o,  0);
        chk("x0_stall", id_stall_o, 0);
        chk("x0_ready", md_ready_o, 1);
        next(); #1;
        chk("x0_not_stored", w_e_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
